// File: rtl/imem_loader.sv
// Instruction-memory loader: streams words into a local RAM, clears it on request,
// then releases the core (run_pc) once a load completes.
module imem_loader #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int AUTO_INC = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W:0]   load_count,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              mem_clr,
   input  logic              run_enable,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              run_pc,
   output logic              load_busy,
   output logic              load_done,
   output logic              overflow_err,
   output logic [DATA_W-1:0] checksum
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;
   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_W:0]   REM_ONE  = 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_DONE, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] csum_q, csum_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              start_acc, accept, mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   assign start_acc = load_start && (state_q == S_IDLE || state_q == S_RUN);
   assign accept    = wr_valid && (state_q == S_LOAD);

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (load_start)   state_d = (load_count == '0) ? S_DONE : S_LOAD;
            else if (mem_clr) state_d = S_CLEAR;
         end
         S_LOAD:  if (accept && rem_q == REM_ONE) state_d = S_DONE;
         S_CLEAR: if (ptr_q == PTR_LAST) state_d = S_IDLE;
         S_DONE:  state_d = run_enable ? S_RUN : S_IDLE;
         S_RUN: begin
            if (load_start)       state_d = (load_count == '0) ? S_DONE : S_LOAD;
            else if (!run_enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      wr_ready     = (state_q == S_LOAD);
      load_busy    = (state_q == S_LOAD) || (state_q == S_CLEAR);
      load_done    = (state_q == S_DONE);
      run_pc       = (state_q == S_RUN);
      overflow_err = ovf_q;
      checksum     = csum_q;
   end

   // Datapath: ptr doubles as the sweep address while clearing
   always_comb begin
      ptr_d  = ptr_q;
      rem_d  = rem_q;
      csum_d = csum_q;
      ovf_d  = ovf_q;
      if (start_acc) begin
         ptr_d  = load_base;
         rem_d  = load_count;
         csum_d = '0;
         ovf_d  = 1'b0;
      end else if (state_q == S_IDLE && mem_clr) begin
         ptr_d = '0;
      end else if (accept) begin
         csum_d = csum_q + wr_data;
         rem_d  = rem_q - REM_ONE;
         ptr_d  = ptr_q + PTR_ONE;
         if (AUTO_INC != 0 && ptr_q == PTR_LAST && rem_q > REM_ONE) ovf_d = 1'b1;
      end else if (state_q == S_CLEAR) begin
         ptr_d = ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr_q  <= '0;
         rem_q  <= '0;
         csum_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         rem_q  <= rem_d;
         csum_q <= csum_d;
         ovf_q  <= ovf_d;
      end
   end

   // Memory has no reset so contents survive reset; writes are suppressed on a reset edge
   assign mem_we    = reset_n && (accept || state_q == S_CLEAR);
   assign mem_waddr = (state_q == S_CLEAR || AUTO_INC != 0) ? ptr_q : wr_addr;
   assign mem_wdata = (state_q == S_CLEAR) ? '0 : wr_data;

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (AUTO_INC=1 and 0) share stimulus,
// each checked against a transaction-level memory/checksum model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset_n, load_start, wr_valid, mem_clr, run_enable;
   logic [7:0]  load_base, wr_addr, rd1, rd0;
   logic [8:0]  load_count;
   logic [31:0] wr_data;

   logic        wr_ready1, run_pc1, busy1, done1, ovf1;
   logic        wr_ready0, run_pc0, busy0, done0, ovf0;
   logic [31:0] rd_data1, csum1, rd_data0, csum0;

   always #5 clk = ~clk;

   imem_loader #(.DATA_W(32), .ADDR_W(8), .AUTO_INC(1)) dut (
      .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_base(load_base),
      .load_count(load_count), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_addr(wr_addr),
      .wr_data(wr_data), .mem_clr(mem_clr), .run_enable(run_enable), .rd_addr(rd1),
      .rd_data(rd_data1), .run_pc(run_pc1), .load_busy(busy1), .load_done(done1),
      .overflow_err(ovf1), .checksum(csum1));

   imem_loader #(.DATA_W(32), .ADDR_W(8), .AUTO_INC(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_base(load_base),
      .load_count(load_count), .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_addr(wr_addr),
      .wr_data(wr_data), .mem_clr(mem_clr), .run_enable(run_enable), .rd_addr(rd0),
      .rd_data(rd_data0), .run_pc(run_pc0), .load_busy(busy0), .load_done(done0),
      .overflow_err(ovf0), .checksum(csum0));

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m1 [256];
   logic [31:0] m0 [256];
   logic [31:0] wq [256];
   logic [7:0]  aq [256];
   logic [31:0] exp_sum;
   logic        exp_ovf;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_mem();
      for (int a = 0; a < 256; a++) begin
         rd1 = 8'(a);
         rd0 = 8'(a);
         #1;
         chk("mem1", rd_data1, m1[a]);
         chk("mem0", rd_data0, m0[a]);
      end
   endtask

   task automatic check_reset_outs();
      chk("rst_rdy1", wr_ready1, 0); chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0);
      chk("rst_run1", run_pc1, 0);   chk("rst_ovf1", ovf1, 0);   chk("rst_csum1", csum1, 0);
      chk("rst_rdy0", wr_ready0, 0); chk("rst_busy0", busy0, 0); chk("rst_done0", done0, 0);
      chk("rst_run0", run_pc0, 0);   chk("rst_ovf0", ovf0, 0);   chk("rst_csum0", csum0, 0);
   endtask

   // One word handshake, optionally preceded by idle gaps carrying junk data
   task automatic push_word(input int base, input int i, input int cnt, input int gapmax);
      int a1, a0, g;
      g = $urandom_range(0, gapmax);
      for (int k = 0; k < g; k++) begin
         wr_valid = 1'b0; wr_data = $urandom; wr_addr = 8'($urandom);
         tick();
      end
      a1 = (base + i) % 256;
      a0 = int'(aq[i]);
      rd1 = 8'(a1); rd0 = 8'(a0);
      wr_valid = 1'b1; wr_data = wq[i]; wr_addr = aq[i];
      #1;
      chk("old1", rd_data1, m1[a1]);
      tick();
      wr_valid = 1'b0;
      m1[a1] = wq[i];
      m0[a0] = wq[i];
      exp_sum = exp_sum + wq[i];
      if (a1 == 255 && i < cnt - 1) exp_ovf = 1'b1;
      chk("new1", rd_data1, m1[a1]);
      chk("new0", rd_data0, m0[a0]);
      chk("ovf_mid1", ovf1, exp_ovf);
      chk("ovf_mid0", ovf0, 0);
   endtask

   task automatic do_load(input int base, input int cnt, input bit run_en, input int gapmax);
      exp_sum = 0;
      exp_ovf = 1'b0;
      run_enable = run_en;
      load_base = 8'(base); load_count = 9'(cnt);
      load_start = 1'b1; mem_clr = 1'($urandom);
      tick();
      load_start = 1'b0; mem_clr = 1'b0;
      chk("start_run1", run_pc1, 0);
      chk("start_ovf1", ovf1, 0);
      chk("start_csum1", csum1, 0);
      if (cnt == 0) begin
         chk("zero_done1", done1, 1);
         chk("zero_busy1", busy1, 0);
         chk("zero_rdy1", wr_ready1, 0);
      end else begin
         chk("start_busy1", busy1, 1);
         chk("start_rdy1", wr_ready1, 1);
         for (int i = 0; i < cnt; i++) begin
            if (i > 0) chk("mid_done1", done1, 0);
            push_word(base, i, cnt, gapmax);
         end
         chk("done1", done1, 1);
         chk("done0", done0, 1);
         chk("done_rdy1", wr_ready1, 0);
         chk("done_busy1", busy1, 0);
      end
      chk("csum1", csum1, exp_sum);
      chk("csum0", csum0, exp_sum);
      chk("ovf1", ovf1, exp_ovf);
      chk("ovf0", ovf0, 0);
      tick();
      chk("post_done1", done1, 0);
      chk("post_run1", run_pc1, run_en);
      chk("post_run0", run_pc0, run_en);
      chk("post_ovf1", ovf1, exp_ovf);
      chk("post_csum1", csum1, exp_sum);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, b, n;
      reset_n = 1'b0; load_start = 1'b0; load_base = '0; load_count = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; mem_clr = 1'b0; run_enable = 1'b0;
      rd1 = '0; rd0 = '0;
      tick(); tick();
      check_reset_outs();
      reset_n = 1'b1;
      tick();

      // Clear sweep: busy for one cycle per address, all zero afterwards
      mem_clr = 1'b1;
      tick();
      mem_clr = 1'b0;
      chk("clr_rdy1", wr_ready1, 0);
      cnt = 0;
      while (busy1 && cnt < 400) begin
         cnt++;
         tick();
      end
      chk("clr_cycles", cnt, 256);
      for (int a = 0; a < 256; a++) begin m1[a] = '0; m0[a] = '0; end
      check_mem();

      // Single word, core released afterwards
      wq[0] = 32'h0053_8193; aq[0] = 8'h00;
      do_load(0, 1, 1'b1, 0);
      chk("single_csum", csum1, 32'h0053_8193);
      run_enable = 1'b0;
      tick();
      chk("run_off1", run_pc1, 0);
      check_mem();

      // Four words with valid gaps
      for (int i = 0; i < 4; i++) begin wq[i] = 32'(i + 1); aq[i] = 8'($urandom); end
      do_load(16, 4, 1'b0, 3);
      chk("gap_csum", csum1, 10);
      check_mem();

      // Wrapping load: sticky overflow survives into RUN
      for (int i = 0; i < 4; i++) begin wq[i] = $urandom; aq[i] = 8'($urandom); end
      do_load(254, 4, 1'b1, 2);
      tick(); tick();
      chk("ovf_sticky1", ovf1, 1);
      check_mem();

      // Explicit addresses, started from RUN; only the AUTO_INC instance flags the wrap
      wq[0] = $urandom; wq[1] = $urandom; aq[0] = 8'h05; aq[1] = 8'h02;
      do_load(255, 2, 1'b0, 1);
      chk("expl_ovf1", ovf1, 1);
      chk("expl_ovf0", ovf0, 0);
      check_mem();

      // Zero-length load goes straight to DONE
      do_load(7, 0, 1'b1, 0);
      run_enable = 1'b0;
      tick();
      chk("zero_runoff", run_pc1, 0);
      check_mem();

      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) begin wq[i] = $urandom; aq[i] = 8'($urandom); end
         do_load(int'($urandom_range(0, 255)), n, 1'($urandom), 2);
         check_mem();
      end
      run_enable = 1'b0;
      tick();

      // Reset in the middle of a load: accepted words persist, the rest never land
      b = int'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) begin wq[i] = $urandom; aq[i] = 8'($urandom); end
      exp_sum = 0; exp_ovf = 1'b0;
      load_base = 8'(b); load_count = 9'd4; load_start = 1'b1;
      tick();
      load_start = 1'b0;
      push_word(b, 0, 4, 1);
      push_word(b, 1, 4, 1);
      tick();
      reset_n = 1'b0;
      tick();
      check_reset_outs();
      reset_n = 1'b1;
      tick();
      check_reset_outs();
      check_mem();

      n = 3;
      for (int i = 0; i < n; i++) begin wq[i] = $urandom; aq[i] = 8'($urandom); end
      do_load(int'($urandom_range(0, 255)), n, 1'b0, 1);
      check_mem();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
